instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Program loader that sits on the write side of the instruction-memory interface, upstream of fetch/decode. It accepts mnemonic-level instruction requests over a valid/ready handshake and encodes each into a 32-bit RV32I word for the opcode subset the decode stage supports: R, I, LW, JALR, S, B, J and U (LUI). It writes the words to consecutive instruction-memory word addresses. Used by the bench and boot path to place programs before releasing the core.

## Interface
- ADDR_W, 8: word-address width of the instruction memory.
- BASE_ADDR, 0: first word address written after `start`.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; honoured only in IDLE or DONE.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 ORI, 7 SLTI, 8 LW, 9 SW, 10 JALR, 11 BEQ, 12 BNE, 13 JAL, 14 LUI, 15 illegal.
- req_rd, req_rs1, req_rs2  in  5 each  register fields; ignored where the format lacks them.
- req_imm  in  32  raw immediate; the encoder selects bits per format.
- req_last  in  1  final instruction of the program.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded word.
- busy  out  1  state is LOAD.
- done  out  1  state is DONE.
- count  out  ADDR_W+1  number of words written since `start`.
- err_illegal  out  1  sticky: an illegal req_op was seen.
- err_overflow  out  1  sticky: the address space was exhausted before req_last.

## Operation
- States: IDLE, LOAD, DONE.
  - IDLE or DONE with `start` → LOAD. This sets ptr=BASE_ADDR, count=0 and clears both error flags.
  - `start` in LOAD is ignored.
- `req_ready` = (state==LOAD) && !full. `full` sets after a write to address 2^ADDR_W−1.
- On acceptance, a registered output stage captures the encoded word and `ptr`. ptr increments modulo 2^ADDR_W, and count increments.
- Acceptance with req_last → DONE.
- If the write to the top address was not marked last, set `full` and err_overflow, then → DONE. No wrap-around write ever occurs.
- Formats (bit fields listed MSB→LSB):
  - R: f7|rs2|rs1|f3|rd|0110011. f7=0100000 for SUB, otherwise 0. f3: ADD/SUB 000, AND 111, OR 110, SLT 010.
  - I: imm[11:0]|rs1|f3|rd|op.
    - ADDI/ORI/SLTI use op 0010011 with f3 000/110/010.
    - LW uses op 0000011, f3 010.
    - JALR uses op 1100111, f3 000.
  - S (SW): imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011. f3 is 000 for BEQ, 001 for BNE.
  - J (JAL): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - U (LUI): imm[31:12]|rd|0110111.
- Illegal req_op (15): the request is accepted and written as NOP 0x00000013, and err_illegal is set.
- Unused immediate bits (e.g. imm[0] for B/J, imm[11:0] for LUI) are ignored. There is no range check.

## Timing
- Reset values:
  - state=IDLE, ptr=BASE_ADDR, count=0, full=0.
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - req_ready=0, busy=0, done=0, err_illegal=0, err_overflow=0.
- Latency: a request accepted on edge N drives mem_we=1 with valid addr/data during cycle N+1, for exactly one cycle. mem_addr/mem_wdata hold until the next write.
- Throughput: one instruction per cycle. Back-to-back acceptances produce a contiguous mem_we burst.
- req_ready is combinational from state/full only. It does not depend on req_valid.
- count updates on the same edge as acceptance.
- done rises on the edge after the last acceptance, coincident with that word's mem_we.
- Reset asserted mid-load aborts immediately. A pending write is dropped: mem_we=0 while rst is high.
- `start` and req_valid in the same IDLE cycle: only the transition happens. req_ready is 0 that cycle.

## Test plan
- ADD x3,x1,x2 then SUB x3,x1,x2 (last) at BASE_ADDR=0 → writes 0x002081B3 @0 and 0x402081B3 @1, count=2, done=1.
- ADDI x1,x0,5 and SW x2,8(x1) → 0x00500093 and 0x0020A423.
- BEQ x1,x2,imm=−4, JAL x1,imm=8, and LUI x5,imm=0x12345000 → 0xFE208EE3, 0x008000EF and 0x123452B7.
- req_op=15 mid-stream → 0x00000013 written, err_illegal=1, following words still written correctly, flag clears on the next `start`.
- ADDR_W=2 with 5 requests and no last → 4 writes @0..3, req_ready drops, err_overflow=1, DONE, no write to address 0.
- Assert rst during a 3-word burst after the 1st acceptance → no further mem_we, all outputs at reset values. A fresh `start` reloads from BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes mnemonic-level requests into RV32I words and writes them
// to consecutive instruction-memory word addresses starting at BASE_ADDR.
module instr_encoder_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    input  logic              req_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_illegal,
    output logic              err_overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_ORI, OP_SLTI,
        OP_LW, OP_SW, OP_JALR, OP_BEQ, OP_BNE, OP_JAL, OP_LUI, OP_ILL
    } op_t;

    localparam logic [6:0]        OPC_R    = 7'b0110011;
    localparam logic [6:0]        OPC_I    = 7'b0010011;
    localparam logic [6:0]        OPC_LW   = 7'b0000011;
    localparam logic [6:0]        OPC_JALR = 7'b1100111;
    localparam logic [6:0]        OPC_S    = 7'b0100011;
    localparam logic [6:0]        OPC_B    = 7'b1100011;
    localparam logic [6:0]        OPC_J    = 7'b1101111;
    localparam logic [6:0]        OPC_U    = 7'b0110111;
    localparam logic [31:0]       NOP      = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              full;
    logic              accept;
    logic              start_take;
    logic              at_top;
    logic [31:0]       enc;
    logic              illegal;

    assign req_ready  = (state == LOAD) && !full;
    assign accept     = req_valid && req_ready;
    assign start_take = start && (state != LOAD);
    assign at_top     = (ptr == TOP_ADDR);
    assign busy       = (state == LOAD);
    assign done       = (state == DONE);

    // NOTE: every variable gets a default at the top of an always_comb so no path can infer a latch.
    always_comb begin
        enc     = NOP;
        illegal = 1'b0;
        case (op_t'(req_op))
            OP_ADD:  enc = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, OPC_R};
            OP_SUB:  enc = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, OPC_R};
            OP_AND:  enc = {7'b0000000, req_rs2, req_rs1, 3'b111, req_rd, OPC_R};
            OP_OR:   enc = {7'b0000000, req_rs2, req_rs1, 3'b110, req_rd, OPC_R};
            OP_SLT:  enc = {7'b0000000, req_rs2, req_rs1, 3'b010, req_rd, OPC_R};
            OP_ADDI: enc = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_I};
            OP_ORI:  enc = {req_imm[11:0], req_rs1, 3'b110, req_rd, OPC_I};
            OP_SLTI: enc = {req_imm[11:0], req_rs1, 3'b010, req_rd, OPC_I};
            OP_LW:   enc = {req_imm[11:0], req_rs1, 3'b010, req_rd, OPC_LW};
            OP_JALR: enc = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_JALR};
            OP_SW:   enc = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], OPC_S};
            OP_BEQ:  enc = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                            req_imm[4:1], req_imm[11], OPC_B};
            OP_BNE:  enc = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b001,
                            req_imm[4:1], req_imm[11], OPC_B};
            OP_JAL:  enc = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                            req_rd, OPC_J};
            OP_LUI:  enc = {req_imm[31:12], req_rd, OPC_U};
            default: begin
                enc     = NOP;
                illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = LOAD;
            LOAD:       if (accept && (req_last || at_top)) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= BASE_ADDR;
            count        <= '0;
            full         <= 1'b0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
        end else begin
            mem_we <= accept;
            if (start_take) begin
                ptr          <= BASE_ADDR;
                count        <= '0;
                full         <= 1'b0;
                err_illegal  <= 1'b0;
                err_overflow <= 1'b0;
            end else if (accept) begin
                mem_addr  <= ptr;
                mem_wdata <= enc;
                ptr       <= ptr + ADDR_W'(1);
                count     <= count + (ADDR_W+1)'(1);
                if (illegal) err_illegal <= 1'b1;
                // The top address is the last writable slot; ptr is never used past it.
                if (at_top) begin
                    full <= 1'b1;
                    if (!req_last) err_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: three instances (default, ADDR_W=2,
// ADDR_W=3 with BASE_ADDR=5) share the request bus; a selected one is driven and compared.
`timescale 1ns/1ps
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        req_last;
    int          sel;

    logic        start0, start1, start2;
    logic        ready0, ready1, ready2;
    logic        we0, we1, we2;
    logic [7:0]  addr0;
    logic [1:0]  addr1;
    logic [2:0]  addr2;
    logic [31:0] wdata0, wdata1, wdata2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [8:0]  count0;
    logic [2:0]  count1;
    logic [3:0]  count2;
    logic        eill0, eill1, eill2;
    logic        eovf0, eovf1, eovf2;

    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);
    assign start2 = start && (sel == 2);

    instr_encoder_loader dut0 (
        .clk(clk), .rst(rst), .start(start0), .req_valid(req_valid), .req_ready(ready0),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .req_last(req_last), .mem_we(we0), .mem_addr(addr0),
        .mem_wdata(wdata0), .busy(busy0), .done(done0), .count(count0),
        .err_illegal(eill0), .err_overflow(eovf0)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .req_valid(req_valid), .req_ready(ready1),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .req_last(req_last), .mem_we(we1), .mem_addr(addr1),
        .mem_wdata(wdata1), .busy(busy1), .done(done1), .count(count1),
        .err_illegal(eill1), .err_overflow(eovf1)
    );

    instr_encoder_loader #(.ADDR_W(3), .BASE_ADDR(3'd5)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .req_valid(req_valid), .req_ready(ready2),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .req_last(req_last), .mem_we(we2), .mem_addr(addr2),
        .mem_wdata(wdata2), .busy(busy2), .done(done2), .count(count2),
        .err_illegal(eill2), .err_overflow(eovf2)
    );

    always #5 clk = ~clk;

    // Outputs of the selected instance, widened to common sizes.
    logic        s_ready, s_we, s_busy, s_done, s_eill, s_eovf;
    logic [7:0]  s_addr;
    logic [8:0]  s_count;
    logic [31:0] s_wdata;

    always_comb begin
        s_ready = ready0; s_we = we0; s_addr = addr0; s_wdata = wdata0;
        s_busy = busy0; s_done = done0; s_count = count0; s_eill = eill0; s_eovf = eovf0;
        if (sel == 1) begin
            s_ready = ready1; s_we = we1; s_addr = {6'd0, addr1}; s_wdata = wdata1;
            s_busy = busy1; s_done = done1; s_count = {6'd0, count1}; s_eill = eill1; s_eovf = eovf1;
        end else if (sel == 2) begin
            s_ready = ready2; s_we = we2; s_addr = {5'd0, addr2}; s_wdata = wdata2;
            s_busy = busy2; s_done = done2; s_count = {5'd0, count2}; s_eill = eill2; s_eovf = eovf2;
        end
    end

    int checks   = 0;
    int failures = 0;

    // Reference model of the selected instance.
    int          m_base, m_top, m_ptr, m_cnt;
    bit          m_active, m_done, m_ill, m_ovf;
    logic [31:0] m_addr, m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_enc(input int op, input int rd, input int rs1,
                                              input int rs2, input logic [31:0] imm);
        logic [31:0] r, a, b, i;
        r = 32'(rd); a = 32'(rs1); b = 32'(rs2); i = imm;
        case (op)
            0:  return (b << 20) | (a << 15) | (r << 7) | 32'h33;
            1:  return (32'h20 << 25) | (b << 20) | (a << 15) | (r << 7) | 32'h33;
            2:  return (b << 20) | (a << 15) | (32'd7 << 12) | (r << 7) | 32'h33;
            3:  return (b << 20) | (a << 15) | (32'd6 << 12) | (r << 7) | 32'h33;
            4:  return (b << 20) | (a << 15) | (32'd2 << 12) | (r << 7) | 32'h33;
            5:  return ((i & 32'hfff) << 20) | (a << 15) | (r << 7) | 32'h13;
            6:  return ((i & 32'hfff) << 20) | (a << 15) | (32'd6 << 12) | (r << 7) | 32'h13;
            7:  return ((i & 32'hfff) << 20) | (a << 15) | (32'd2 << 12) | (r << 7) | 32'h13;
            8:  return ((i & 32'hfff) << 20) | (a << 15) | (32'd2 << 12) | (r << 7) | 32'h03;
            9:  return (((i >> 5) & 32'h7f) << 25) | (b << 20) | (a << 15) | (32'd2 << 12)
                       | ((i & 32'h1f) << 7) | 32'h23;
            10: return ((i & 32'hfff) << 20) | (a << 15) | (r << 7) | 32'h67;
            11, 12: return (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3f) << 25)
                       | (b << 20) | (a << 15) | (32'(op - 11) << 12)
                       | (((i >> 1) & 32'hf) << 8) | (((i >> 11) & 32'h1) << 7) | 32'h63;
            13: return (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3ff) << 21)
                       | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hff) << 12)
                       | (r << 7) | 32'h6f;
            14: return (i & 32'hffff_f000) | (r << 7) | 32'h37;
            default: return 32'h0000_0013;
        endcase
    endfunction

    task automatic model_reset();
        m_active = 0; m_done = 0; m_ill = 0; m_ovf = 0;
        m_ptr = m_base; m_cnt = 0; m_addr = 32'(m_base); m_data = 32'd0;
    endtask

    task automatic select_inst(input int k);
        sel = k;
        m_base = (k == 2) ? 5 : 0;
        m_top  = (k == 0) ? 255 : ((k == 1) ? 3 : 7);
        model_reset();
    endtask

    task automatic check_outputs(input string tag, input bit exp_we);
        check({tag, ".we"},    32'(s_we),    32'(exp_we));
        check({tag, ".addr"},  32'(s_addr),  m_addr);
        check({tag, ".data"},  s_wdata,      m_data);
        check({tag, ".count"}, 32'(s_count), 32'(m_cnt));
        check({tag, ".busy"},  32'(s_busy),  32'(m_active));
        check({tag, ".done"},  32'(s_done),  32'(m_done));
        check({tag, ".eill"},  32'(s_eill),  32'(m_ill));
        check({tag, ".eovf"},  32'(s_eovf),  32'(m_ovf));
    endtask

    // One clock cycle with the inputs already driven; entered and left at a falling edge.
    task automatic cycle(input string tag);
        bit exp_we;
        check({tag, ".ready"}, 32'(s_ready), 32'(m_active));
        exp_we = 0;
        if (req_valid && m_active) begin
            exp_we = 1;
            m_addr = 32'(m_ptr);
            m_data = model_enc(int'(req_op), int'(req_rd), int'(req_rs1), int'(req_rs2), req_imm);
            m_cnt++;
            if (req_op == 4'd15) m_ill = 1;
            if (req_last) begin
                m_active = 0; m_done = 1;
            end else if (m_ptr == m_top) begin
                m_active = 0; m_done = 1; m_ovf = 1;
            end
            m_ptr++;
        end else if (start && !m_active) begin
            m_active = 1; m_done = 0; m_ill = 0; m_ovf = 0; m_ptr = m_base; m_cnt = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag, exp_we);
        @(negedge clk);
    endtask

    task automatic req(input int op, input int rd, input int rs1, input int rs2,
                       input logic [31:0] imm, input bit last);
        req_valid = 1'b1; req_op = 4'(op); req_rd = 5'(rd); req_rs1 = 5'(rs1);
        req_rs2 = 5'(rs2); req_imm = imm; req_last = last;
        cycle($sformatf("req_op%0d", op));
    endtask

    task automatic idle();
        req_valid = 1'b0; req_last = 1'b0;
        cycle("idle");
    endtask

    task automatic do_start();
        start = 1'b1; req_valid = 1'b0;
        cycle("start");
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; req_valid = 1'b0; req_last = 1'b0;
        req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        select_inst(0);
        repeat (3) @(negedge clk);
        check("rst.ready", 32'(s_ready), 32'd0);
        check_outputs("rst", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        idle();

        // start together with a valid request in IDLE: only the transition happens
        start = 1'b1;
        req(0, 3, 1, 2, 32'd0, 1'b0);
        start = 1'b0;

        // ADD x3,x1,x2 ; SUB x3,x1,x2 (last)
        req(0, 3, 1, 2, 32'd0, 1'b0);
        check("gold.add", s_wdata, 32'h002081B3);
        req(1, 3, 1, 2, 32'd0, 1'b1);
        check("gold.sub", s_wdata, 32'h402081B3);
        check("gold.sub_addr", 32'(s_addr), 32'd1);
        idle();
        idle();

        // restart from DONE; also start during LOAD must be ignored
        do_start();
        req(5, 1, 0, 0, 32'd5, 1'b0);
        check("gold.addi", s_wdata, 32'h00500093);
        start = 1'b1;
        req(9, 0, 1, 2, 32'd8, 1'b0);
        start = 1'b0;
        check("gold.sw", s_wdata, 32'h0020A423);
        req(11, 0, 1, 2, 32'hFFFF_FFFC, 1'b0);
        check("gold.beq", s_wdata, 32'hFE208EE3);
        idle();
        req(13, 1, 0, 0, 32'd8, 1'b0);
        check("gold.jal", s_wdata, 32'h008000EF);
        req(14, 5, 0, 0, 32'h1234_5000, 1'b1);
        check("gold.lui", s_wdata, 32'h123452B7);
        check("gold.count", 32'(s_count), 32'd5);
        idle();

        // illegal op mid-stream
        do_start();
        req(2, 4, 5, 6, $urandom, 1'b0);
        req(15, 7, 7, 7, $urandom, 1'b0);
        check("gold.nop", s_wdata, 32'h00000013);
        req(10, 1, 2, 0, $urandom, 1'b0);
        req(12, 0, 3, 4, $urandom, 1'b1);
        idle();
        do_start();
        check("ill.cleared", 32'(s_eill), 32'd0);

        // randomized burst with gaps
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else req($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom, i == 39);
        end
        if (m_active) req($urandom_range(0, 14), 1, 2, 3, $urandom, 1'b1);
        idle();

        // reset in the middle of a 3-word burst
        do_start();
        req(15, 0, 0, 0, 32'd0, 1'b0);
        req_op = 4'd0; req_rd = 5'd9; req_last = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst.ready", 32'(s_ready), 32'd0);
        check_outputs("midrst", 1'b0);
        @(posedge clk);
        #1;
        check_outputs("midrst2", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        do_start();
        req(3, 8, 9, 10, 32'd0, 1'b0);
        req(4, 8, 9, 10, 32'd0, 1'b1);
        idle();

        // ADDR_W=2: five requests without last overflow after four writes
        select_inst(1);
        do_start();
        for (int i = 0; i < 5; i++)
            req($urandom_range(0, 14), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom, 1'b0);
        check("ovf.flag", 32'(s_eovf), 32'd1);
        check("ovf.addr", 32'(s_addr), 32'd3);
        idle();

        // ADDR_W=3, BASE_ADDR=5: last on the top address, then overflow
        select_inst(2);
        do_start();
        for (int i = 0; i < 3; i++)
            req($urandom_range(0, 14), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom, i == 2);
        check("top_last.eovf", 32'(s_eovf), 32'd0);
        idle();
        do_start();
        for (int i = 0; i < 4; i++)
            req($urandom_range(0, 14), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom, 1'b0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
